// File: rtl/execute_pkg.sv
// execute_pkg: pipeline register types shared by the EX, MEM and WB stages
package execute_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_mem_t;
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_to_reg;
  } mem_wb_t;
endpackage

// File: rtl/memory_pkg.sv
// memory_pkg: MEM-stage state, retire causes and timeout counter sizing
package memory_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} mem_state_t;
  typedef enum logic [1:0] {RC_OK, RC_MISALIGNED, RC_TIMEOUT} retire_cause_t;
  localparam logic [3:0] WSTRB_WORD = 4'hF;
  function automatic int tcnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/dmem_port_fsm.sv
// dmem_port_fsm: data-memory handshake sequencing, stall generation and timeout abort
module dmem_port_fsm
  import memory_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_op,
  input  logic          is_load,
  input  logic          misalign,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic          mem_stall,
  output logic          retire,
  output retire_cause_t cause
);
  localparam int TW = tcnt_width(TIMEOUT_CYCLES);
  mem_state_t state, next;
  logic [TW-1:0] cnt;
  logic expired, req_c, stall_c, retire_c;
  assign expired = cnt == TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (next != state || state == IDLE) ? '0 : cnt + 1'b1;
    end
  end
  always_comb begin
    next     = state;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    retire_c = 1'b0;
    cause    = RC_OK;
    case (state)
      IDLE: begin
        if (!mem_op) retire_c = 1'b1;
        else if (misalign) begin
          retire_c = 1'b1;
          cause    = RC_MISALIGNED;
        end else begin
          req_c = 1'b1;
          if (!is_load && dmem_gnt) retire_c = 1'b1;
          else begin
            stall_c = 1'b1;
            next    = dmem_gnt ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req_c = 1'b1;
        if (dmem_gnt && !is_load) begin
          retire_c = 1'b1;
          next     = IDLE;
        end else if (dmem_gnt) begin
          stall_c = 1'b1;
          next    = WAIT_RVALID;
        end else if (expired) begin
          retire_c = 1'b1;
          cause    = RC_TIMEOUT;
          next     = IDLE;
        end else stall_c = 1'b1;
      end
      WAIT_RVALID: begin
        if (dmem_rvalid) begin
          retire_c = 1'b1;
          next     = IDLE;
        end else if (expired) begin
          retire_c = 1'b1;
          cause    = RC_TIMEOUT;
          next     = IDLE;
        end else stall_c = 1'b1;
      end
      default: next = IDLE;
    endcase
  end
  assign dmem_req  = req_c & ~reset;
  assign dmem_we   = dmem_req & ~is_load;
  assign mem_stall = stall_c & ~reset;
  assign retire    = retire_c & ~reset;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: RV32 MEM stage driving the data-memory bus and the MEM/WB register
module memory_stage
  import execute_pkg::*;
  import memory_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  ex_mem_t         ex_mem,
  output mem_wb_t         mem_wb,
  output logic            mem_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            misaligned,
  output logic            bus_error
);
  logic          mem_op, is_load, misalign, retire;
  retire_cause_t cause;
  mem_wb_t       wb_next;
  assign mem_op   = ex_mem.mem_read | ex_mem.mem_write;
  assign is_load  = ex_mem.mem_read;
  assign misalign = |ex_mem.alu_result[1:0];
  dmem_port_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_op      (mem_op),
    .is_load     (is_load),
    .misalign    (misalign),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .mem_stall   (mem_stall),
    .retire      (retire),
    .cause       (cause)
  );
  assign dmem_addr  = ex_mem.alu_result;
  assign dmem_wdata = ex_mem.rs2_data;
  assign dmem_wstrb = dmem_we ? WSTRB_WORD : 4'h0;
  assign misaligned = retire && cause == RC_MISALIGNED;
  assign bus_error  = retire && cause == RC_TIMEOUT;
  // Only a load completing normally carries bus data; every other retirement writes 0
  always_comb begin
    wb_next            = '0;
    wb_next.data       = (cause == RC_OK && is_load) ? dmem_rdata : '0;
    wb_next.alu_result = ex_mem.alu_result;
    wb_next.rd         = ex_mem.rd;
    wb_next.reg_write  = ex_mem.reg_write;
    wb_next.mem_to_reg = ex_mem.mem_to_reg;
  end
  always_ff @(posedge clk) begin
    if (reset) mem_wb <= '0;
    else mem_wb <= mem_stall ? '0 : wb_next;
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of the MEM stage handshake, stalls, misalignment and timeout
module tb_memory_stage;
  import execute_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, misaligned, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  int checks = 0;
  int errors = 0;
  memory_stage #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_mem      (ex_mem),
    .mem_wb      (mem_wb),
    .mem_stall   (mem_stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .misaligned  (misaligned),
    .bus_error   (bus_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic ex_mem_t em(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw, input logic m2r);
    ex_mem_t e;
    e.alu_result = alu;
    e.rs2_data   = rs2;
    e.rd         = rd;
    e.reg_write  = rw;
    e.mem_read   = mr;
    e.mem_write  = mw;
    e.mem_to_reg = m2r;
    return e;
  endfunction
  function automatic mem_wb_t wb(input logic [31:0] data, input logic [31:0] alu, input logic [4:0] rd,
                                 input logic rw, input logic m2r);
    mem_wb_t w;
    w.data       = data;
    w.alu_result = alu;
    w.rd         = rd;
    w.reg_write  = rw;
    w.mem_to_reg = m2r;
    return w;
  endfunction
  initial begin
    reset       = 1'b1;
    ex_mem      = em(32'h200, 0, 5'd1, 1, 1, 0, 1);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    cyc();
    cyc();
    chk("rst_wb", mem_wb, 0);
    ex_mem = em(32'h1234, 0, 5'd5, 1, 0, 0, 0);
    reset  = 1'b0;
    #1;
    chk("alu_req", dmem_req, 0);
    chk("alu_stall", mem_stall, 0);
    cyc();
    chk("alu_wb", mem_wb, wb(0, 32'h1234, 5'd5, 1, 0));
    ex_mem   = em(32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0);
    dmem_gnt = 1'b1;
    #1;
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wstrb", dmem_wstrb, 4'hF);
    chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("st_addr", dmem_addr, 32'h100);
    chk("st_stall", mem_stall, 0);
    cyc();
    chk("st_wb", mem_wb, wb(0, 32'h100, 5'd0, 0, 0));
    ex_mem   = em(32'h200, 0, 5'd7, 1, 1, 0, 1);
    dmem_gnt = 1'b0;
    dmem_rdata = 32'hCAFEF00D;
    for (int i = 0; i <= 5; i++) begin
      dmem_gnt    = (i == 3);
      dmem_rvalid = (i == 5);
      #1;
      chk($sformatf("ld_stall%0d", i), mem_stall, i < 5);
      chk($sformatf("ld_req%0d", i), dmem_req, i <= 3);
      if (i <= 3) chk($sformatf("ld_addr%0d", i), dmem_addr, 32'h200);
      if (i == 0) chk("ld_we", {dmem_we, dmem_wstrb}, 0);
      cyc();
      if (i < 5) chk($sformatf("ld_bubble%0d", i), mem_wb, 0);
      else chk("ld_wb", mem_wb, wb(32'hCAFEF00D, 32'h200, 5'd7, 1, 1));
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    ex_mem = em(32'h202, 0, 5'd4, 1, 1, 0, 1);
    #1;
    chk("mis_ld_req", dmem_req, 0);
    chk("mis_ld_pulse", misaligned, 1);
    chk("mis_ld_stall", mem_stall, 0);
    cyc();
    chk("mis_ld_wb", mem_wb, wb(0, 32'h202, 5'd4, 1, 1));
    ex_mem = em(32'h101, 32'h12345678, 5'd0, 0, 0, 1, 0);
    #1;
    chk("mis_st_req", {dmem_req, dmem_we}, 0);
    chk("mis_st_pulse", misaligned, 1);
    cyc();
    chk("mis_st_wb", mem_wb, wb(0, 32'h101, 5'd0, 0, 0));
    ex_mem = em(32'h300, 0, 5'd9, 1, 1, 0, 1);
    #1;
    chk("mis_clear", misaligned, 0);
    dmem_gnt = 1'b1;
    #1;
    chk("to_stall0", mem_stall, 1);
    cyc();
    dmem_gnt = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      #1;
      chk($sformatf("to_berr%0d", i), bus_error, i == 4);
      chk($sformatf("to_stall%0d", i + 1), mem_stall, i < 4);
      cyc();
    end
    chk("to_wb", mem_wb, wb(0, 32'h300, 5'd9, 1, 1));
    ex_mem      = em(32'h0, 0, 5'd0, 0, 0, 0, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55;
    #1;
    chk("stray_pulses", {bus_error, misaligned, mem_stall}, 0);
    cyc();
    chk("stray_wb", mem_wb, 0);
    dmem_rvalid = 1'b0;
    ex_mem   = em(32'h400, 0, 5'd3, 1, 1, 0, 1);
    dmem_gnt = 1'b1;
    #1;
    cyc();
    dmem_gnt = 1'b0;
    #1;
    chk("rmid_wait", mem_stall, 1);
    cyc();
    reset = 1'b1;
    #1;
    chk("rmid_outs", {dmem_req, mem_stall, misaligned, bus_error}, 0);
    cyc();
    reset       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h77;
    #1;
    chk("rmid_wb_rst", mem_wb, 0);
    chk("rmid_pulses", {misaligned, bus_error}, 0);
    chk("rmid_idle_req", dmem_req, 1);
    cyc();
    chk("rmid_wb", mem_wb, 0);
    dmem_rvalid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline.
- Consumes the EX/MEM register, issues word loads/stores on the data-memory request/grant/response bus, and drives the MEM/WB register.
- Stalls upstream stages while a memory access is outstanding.
- Handles misaligned addresses and bus timeouts so the pipeline never hangs.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, max cycles spent in one wait state before the access is aborted with bus_error.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ex_mem  input  execute_pkg::ex_mem_t  EX/MEM register: alu_result, rs2_data, rd, reg_write, mem_read, mem_write, mem_to_reg.
- mem_wb  output  execute_pkg::mem_wb_t  MEM/WB register: data, alu_result, rd, reg_write, mem_to_reg.
- mem_stall  output  1  hold IF/ID/EX and EX/MEM this cycle.
- dmem_req  output  1  request valid.
- dmem_we  output  1  1 = store.
- dmem_addr  output  XLEN  byte address, taken from alu_result.
- dmem_wdata  output  XLEN  store data, taken from rs2_data.
- dmem_wstrb  output  4  always 4'hF when dmem_we = 1, else 0.
- dmem_gnt  input  1  request accepted this cycle.
- dmem_rvalid  input  1  load data valid; never earlier than the cycle after gnt.
- dmem_rdata  input  XLEN  load data.
- misaligned  output  1  one-cycle pulse when a misaligned access retires.
- bus_error  output  1  one-cycle pulse when an access retires by timeout.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Synchronous active-high reset: mem_wb <= '0, state <= IDLE, timeout counter <= 0.
  - While reset is high: dmem_req, mem_stall, misaligned and bus_error are 0.
- Memory op: defined as mem_read | mem_write.
  - mem_read and mem_write both set is illegal; treat as a load.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, no memory op:
  - Retire immediately, mem_stall = 0.
  - mem_wb <= {data: 0, alu_result, rd, reg_write, mem_to_reg}.
- IDLE, memory op with alu_result[1:0] != 0 (misaligned):
  - No dmem_req.
  - Retire this cycle: misaligned = 1, mem_wb.data = 0.
  - A store is suppressed; a load still writes rd with 0.
- IDLE, aligned memory op:
  - dmem_req = 1 combinationally, with addr/we/wdata/wstrb driven from ex_mem.
  - Store with gnt = 1: retire this cycle, stay IDLE.
  - Store with gnt = 0: mem_stall = 1, go to WAIT_GNT.
  - Load with gnt = 1: mem_stall = 1, go to WAIT_RVALID.
  - Load with gnt = 0: mem_stall = 1, go to WAIT_GNT.
- WAIT_GNT:
  - dmem_req held with identical address/data; ex_mem is held stable by the stall.
  - On gnt: a store retires and goes to IDLE; a load goes to WAIT_RVALID.
  - mem_stall = 1 except in the cycle a store retires.
- WAIT_RVALID:
  - dmem_req = 0, mem_stall = 1 until rvalid.
  - On rvalid: retire with mem_wb.data = dmem_rdata, mem_stall = 0, go to IDLE.
- Timeout:
  - Counter increments every cycle in WAIT_GNT/WAIT_RVALID and clears on any state change.
  - When counter == TIMEOUT_CYCLES and the wait condition is still unmet, retire anyway: bus_error = 1, mem_wb.data = 0, go to IDLE.
- Stall bubble: in any cycle with mem_stall = 1, mem_wb <= bubble (reg_write = 0, rd = 0, mem_to_reg = 0). This prevents double writeback.
- Latency:
  - Non-memory ops and stores with immediate gnt: 1 cycle from EX/MEM to MEM/WB.
  - Loads: minimum 2 cycles; one stall cycle when rvalid arrives the cycle after gnt.
- Stray responses: dmem_rvalid in IDLE or WAIT_GNT is ignored. This covers a response to an access abandoned by reset or timeout.
- Reset mid-access: abandon the access, go to IDLE next cycle, no retirement, no pulses.

Decomposition:
- memory_pkg:
  - mem_state_t enum {IDLE, WAIT_GNT, WAIT_RVALID}.
  - WSTRB_WORD = 4'hF.
  - Timeout-counter width derived from $clog2(TIMEOUT_CYCLES+1).
- ex_mem_t and mem_wb_t remain in execute_pkg.
- One sub-module, dmem_port_fsm:
  - Contains the state register, timeout counter, dmem_req/we and mem_stall.
  - Outputs a retire strobe and a retire cause (ok, misaligned, timeout).
- memory_stage owns the mem_wb register and the data mux.

Test Plan:
- ALU op (reg_write = 1, rd = 5, alu_result = 0x1234, no mem op) -> next cycle mem_wb = {rd 5, reg_write 1, alu_result 0x1234}; mem_stall and dmem_req never high.
- Store, addr 0x100, rs2_data 0xDEADBEEF, gnt in the same cycle -> dmem_req/we high for 1 cycle with wstrb F and wdata 0xDEADBEEF; no stall.
- Load, addr 0x200, gnt after 3 cycles, rvalid 2 cycles later with rdata 0xCAFEF00D -> mem_stall high 5 cycles; addr held stable; 5 bubble cycles in mem_wb; then mem_wb.data = 0xCAFEF00D with reg_write 1.
- Load, addr 0x202 -> no dmem_req; misaligned pulses 1 cycle; mem_wb.data = 0. Store, addr 0x101 -> no dmem_req, misaligned pulses.
- TIMEOUT_CYCLES = 4, load whose rvalid never arrives -> bus_error pulse after 4 cycles in WAIT_RVALID; retire with data 0; a later stray rvalid in IDLE causes no change to mem_wb.
- Reset asserted while in WAIT_RVALID, rvalid arrives in the cycle after reset deasserts -> state IDLE; mem_wb = 0; no retirement and no pulses.
